// File: rtl/cpu_control_fsm_pkg.sv
// tron_pkg: shared definitions for the CPU control sequencer.
//   - state_t       : control FSM state encoding
//   - OP_*          : 8-bit decoded opcode constants (also used by the
//                     sign-extend and ALU decode logic)
//   - op_byte()     : forms the 8-bit opcode from the two IR nibbles
package tron_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  // Register-register ALU ops (ir[15:12] = 0000, sub-opcode in ir[7:4])
  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_SUB   = 8'h09;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_MOV   = 8'h0D;
  // Immediate ALU ops
  localparam logic [7:0] OP_ANDI  = 8'h10;
  localparam logic [7:0] OP_ADDI  = 8'h50;
  localparam logic [7:0] OP_LSHI0 = 8'h80;
  localparam logic [7:0] OP_LSHI1 = 8'h81;
  localparam logic [7:0] OP_SUBI  = 8'h90;
  localparam logic [7:0] OP_CMPI  = 8'hB0;
  // Memory and control flow
  localparam logic [7:0] OP_LOAD  = 8'h40;
  localparam logic [7:0] OP_STOR  = 8'h44;
  localparam logic [7:0] OP_BCOND = 8'hC0;

  // Only the 0x0, 0x4 and 0x8 major groups carry a sub-opcode in ir[7:4];
  // everywhere else ir[7:4] is immediate/register data and is masked off.
  function automatic logic [7:0] op_byte(input logic [3:0] hi, input logic [3:0] lo);
    if (hi == 4'h0 || hi == 4'h4 || hi == 4'h8) return {hi, lo};
    else                                          return {hi, 4'h0};
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// cpu_control_fsm_if: controller <-> datapath/memory signal bundle.
//   master : the control FSM (drives strobes and instruction_op)
//   slave  : datapath / memory side (drives instruction, mem_ready, flag_cond)
interface cpu_control_fsm_if;
  logic [15:0] instruction;
  logic        mem_ready;
  logic        flag_cond;
  logic [7:0]  instruction_op;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_branch;
  logic        alu_src_imm;
  logic        reg_write;
  logic        psr_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_addr_sel;

  modport master (
    input  instruction, mem_ready, flag_cond,
    output instruction_op, ir_load, pc_inc, pc_branch, alu_src_imm,
           reg_write, psr_write, mem_read, mem_write, mem_addr_sel
  );

  modport slave (
    output instruction, mem_ready, flag_cond,
    input  instruction_op, ir_load, pc_inc, pc_branch, alu_src_imm,
           reg_write, psr_write, mem_read, mem_write, mem_addr_sel
  );
endinterface

// File: rtl/cpu_control_fsm_op_decode.sv
// op_decode: combinational instruction classifier.
//   ir_i         : latched instruction register
//   op_o         : 8-bit opcode byte
//   is_imm_o     : immediate ALU op (ALU B from extended immediate)
//   is_reg_o     : register-register ALU op (major group 0x0)
//   is_branch_o  : BCOND
//   is_load_o    : LOAD
//   is_store_o   : STOR
//   writes_reg_o : result written to register file in WRITEBACK
//   writes_psr_o : PSR flags updated in WRITEBACK
// Anything not classified above is an undefined opcode and executes as NOP.
module op_decode
  import tron_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [7:0]  op_o,
  output logic        is_imm_o,
  output logic        is_reg_o,
  output logic        is_branch_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        writes_reg_o,
  output logic        writes_psr_o
);

  // Register fields and immediate bits are consumed by the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir_i[11:8], ir_i[3:0]};

  assign op_o = op_byte(ir_i[15:12], ir_i[7:4]);

  always_comb begin
    is_imm_o     = 1'b0;
    is_branch_o  = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    writes_psr_o = 1'b0;
    is_reg_o     = (op_o[7:4] == 4'h0);
    unique case (op_o)
      OP_ANDI, OP_ADDI, OP_SUBI, OP_CMPI, OP_LSHI0, OP_LSHI1: is_imm_o = 1'b1;
      OP_BCOND: is_branch_o = 1'b1;
      OP_LOAD:  is_load_o   = 1'b1;
      OP_STOR:  is_store_o  = 1'b1;
      default: ;
    endcase
    unique case (op_o)
      OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: writes_psr_o = 1'b1;
      default: ;
    endcase
    // Compares only set flags.
    writes_reg_o = (is_imm_o && op_o != OP_CMPI) ||
                   (is_reg_o && op_o != OP_CMP)  ||
                   is_load_o;
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle instruction sequencer.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : cpu_control_fsm_if.master (instruction/handshake in, strobes out)
// Build option MEM_HANDSHAKE_EN: when defined, FETCH and MEM wait for
// mem_ready; when undefined, mem_ready is ignored and each takes one cycle.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FETCH     | read memory at PC; on completion latch IR and bump PC
// DECODE    | one cycle for instruction_op to settle downstream
// EXECUTE   | ALU operand select, branch, or dispatch to MEM
// MEM       | LOAD/STOR data access at register address
// WRITEBACK | register file / PSR update
module cpu_control_fsm
  import tron_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  cpu_control_fsm_if.master bus
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        mem_ok;
  logic        ir_load, pc_inc, pc_branch, alu_src_imm;
  logic        reg_write, psr_write, mem_read, mem_write, mem_addr_sel;
  logic        is_imm, is_reg, is_branch, is_load, is_store;
  logic        writes_reg, writes_psr;
  logic [7:0]  op;

`ifdef MEM_HANDSHAKE_EN
  assign mem_ok = bus.mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok = 1'b1;
`endif

  // Decoding from the latched IR keeps instruction_op stable from DECODE
  // through WRITEBACK; reset clears IR so the opcode reads 0x00.
  op_decode u_op_decode (
    .ir_i         (ir_q),
    .op_o         (op),
    .is_imm_o     (is_imm),
    .is_reg_o     (is_reg),
    .is_branch_o  (is_branch),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .writes_reg_o (writes_reg),
    .writes_psr_o (writes_psr)
  );

  assign ir_d = ir_load ? bus.instruction : ir_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes are gated by reset_n so that asserting reset drops them
  // immediately, even though FETCH is the reset state.
  always_comb begin
    state_d      = state_q;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_branch    = 1'b0;
    alu_src_imm  = 1'b0;
    reg_write    = 1'b0;
    psr_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ok) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: state_d = ST_EXECUTE;
        ST_EXECUTE: begin
          if (is_imm) begin
            alu_src_imm = 1'b1;
            state_d     = ST_WRITEBACK;
          end else if (is_reg) begin
            state_d = ST_WRITEBACK;
          end else if (is_branch) begin
            pc_branch = bus.flag_cond;
            state_d   = ST_FETCH;
          end else if (is_load || is_store) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_MEM: begin
          mem_addr_sel = 1'b1;
          mem_read     = is_load;
          mem_write    = is_store;
          if (mem_ok) state_d = is_load ? ST_WRITEBACK : ST_FETCH;
        end
        ST_WRITEBACK: begin
          reg_write = writes_reg;
          psr_write = writes_psr;
          state_d   = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign bus.instruction_op = op;
  assign bus.ir_load        = ir_load;
  assign bus.pc_inc         = pc_inc;
  assign bus.pc_branch      = pc_branch;
  assign bus.alu_src_imm    = alu_src_imm;
  assign bus.reg_write      = reg_write;
  assign bus.psr_write      = psr_write;
  assign bus.mem_read       = mem_read;
  assign bus.mem_write      = mem_write;
  assign bus.mem_addr_sel   = mem_addr_sel;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: table of instruction vectors with
// hand-computed per-instruction outcomes, plus reset sequences.
module tb_cpu_control_fsm;
  import tron_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  cpu_control_fsm_if bus();

  cpu_control_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  typedef struct {
    logic [15:0] instr;
    logic        flag;
    int          fwait;  // cycles mem_ready held low in first FETCH
    int          mwait;  // cycles mem_ready held low in MEM
    logic [7:0]  op;
    int          imm;    // alu_src_imm in EXECUTE
    int          br;     // pc_branch cycles
    int          rw;     // reg_write cycles
    int          pw;     // psr_write cycles
    int          rd;     // MEM-phase mem_read cycles with zero wait
    int          wr;     // MEM-phase mem_write cycles with zero wait
    int          lat;    // cycles from FETCH to next FETCH with zero wait
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  // observations from one instruction
  int o_op_dec, o_op_end, o_imm_ex, o_imm_cnt, o_br, o_rw, o_rwc, o_pw;
  int o_rd, o_wr, o_pc, o_irl, o_lat, o_timeout;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a falling edge with the DUT in FETCH. Returns at the falling
  // edge of the next FETCH after the instruction has completed.
  task automatic run_instr(input logic [15:0] ins, input logic flag,
                           input int fwait, input int mwait);
    int  c, k, fw, mw;
    bit  in_fetch, done;
    o_op_dec = -1; o_op_end = -1; o_imm_ex = -1; o_imm_cnt = 0;
    o_br = 0; o_rw = 0; o_rwc = 0; o_pw = 0; o_rd = 0; o_wr = 0;
    o_pc = 0; o_irl = 0; o_lat = 0; o_timeout = 0;
    bus.instruction = ins;
    bus.flag_cond   = flag;
    fw = fwait; mw = mwait;
    c = 1; k = 0; done = 0;
    while (!done) begin
      in_fetch = bus.mem_read && !bus.mem_addr_sel;
      if (in_fetch && k > 0) begin
        o_lat = c - 1;
        done  = 1;
      end else if (c > 40) begin
        o_timeout = 1;
        done      = 1;
      end else begin
        if (in_fetch && fw > 0) begin
          bus.mem_ready = 1'b0;
          fw--;
        end else if (bus.mem_addr_sel && mw > 0) begin
          bus.mem_ready = 1'b0;
          mw--;
        end else begin
          bus.mem_ready = 1'b1;
        end
        #1;
        if (!in_fetch) begin
          k++;
          if (k == 1) o_op_dec = int'(bus.instruction_op);
          if (k == 2) o_imm_ex = int'(bus.alu_src_imm);
          o_op_end = int'(bus.instruction_op);
        end
        o_imm_cnt += int'(bus.alu_src_imm);
        o_br      += int'(bus.pc_branch);
        o_pw      += int'(bus.psr_write);
        o_pc      += int'(bus.pc_inc);
        o_irl     += int'(bus.ir_load);
        if (bus.reg_write) begin
          o_rw++;
          o_rwc = c;
        end
        if (bus.mem_addr_sel) begin
          o_rd += int'(bus.mem_read);
          o_wr += int'(bus.mem_write);
        end
        @(posedge clk);
        @(negedge clk);
        c++;
      end
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int lat_t, rd_t, wr_t, wcnt, lcnt;
    vecs = '{
      '{16'h51FD, 1'b1, 0, 0, 8'h50, 1, 0, 1, 1, 0, 0, 4},  // ADDI r1,#-3
      '{16'h51FD, 1'b0, 2, 0, 8'h50, 1, 0, 1, 1, 0, 0, 4},  // ADDI, slow fetch
      '{16'h0152, 1'b1, 0, 0, 8'h05, 0, 0, 1, 1, 0, 0, 4},  // ADD
      '{16'h01B3, 1'b0, 0, 0, 8'h0B, 0, 0, 0, 1, 0, 0, 4},  // CMP
      '{16'h0112, 1'b0, 0, 0, 8'h01, 0, 0, 1, 0, 0, 0, 4},  // AND
      '{16'h0391, 1'b0, 0, 0, 8'h09, 0, 0, 1, 1, 0, 0, 4},  // SUB
      '{16'hB105, 1'b1, 0, 0, 8'hB0, 1, 0, 0, 1, 0, 0, 4},  // CMPI
      '{16'h1234, 1'b0, 0, 0, 8'h10, 1, 0, 1, 0, 0, 0, 4},  // ANDI
      '{16'h8312, 1'b0, 0, 0, 8'h81, 1, 0, 1, 0, 0, 0, 4},  // LSHI 0x81
      '{16'h8305, 1'b0, 0, 0, 8'h80, 1, 0, 1, 0, 0, 0, 4},  // LSHI 0x80
      '{16'h9207, 1'b0, 0, 0, 8'h90, 1, 0, 1, 1, 0, 0, 4},  // SUBI
      '{16'hC03A, 1'b1, 0, 0, 8'hC0, 0, 1, 0, 0, 0, 0, 3},  // BCOND taken
      '{16'hC1F0, 1'b0, 0, 0, 8'hC0, 0, 0, 0, 0, 0, 0, 3},  // BCOND not taken
      '{16'h4203, 1'b0, 0, 0, 8'h40, 0, 0, 1, 0, 1, 0, 5},  // LOAD
      '{16'h4203, 1'b0, 0, 3, 8'h40, 0, 0, 1, 0, 1, 0, 5},  // LOAD, 3 wait
      '{16'h4145, 1'b0, 0, 0, 8'h44, 0, 0, 0, 0, 0, 1, 4},  // STOR
      '{16'h4145, 1'b1, 0, 2, 8'h44, 0, 0, 0, 0, 0, 1, 4},  // STOR, 2 wait
      '{16'hF000, 1'b1, 0, 0, 8'hF0, 0, 0, 0, 0, 0, 0, 3},  // undefined 0xF0
      '{16'h4123, 1'b0, 0, 0, 8'h42, 0, 0, 0, 0, 0, 0, 3},  // undefined 0x42
      '{16'h8325, 1'b1, 0, 0, 8'h82, 0, 0, 0, 0, 0, 0, 3}   // undefined 0x82
    };

    reset_n         = 1'b0;
    bus.instruction = 16'h0000;
    bus.mem_ready   = 1'b0;
    bus.flag_cond   = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_op",       int'(bus.instruction_op), 0);
    check("rst_strobes",  int'({bus.ir_load, bus.pc_inc, bus.pc_branch, bus.alu_src_imm,
                                bus.reg_write, bus.psr_write, bus.mem_read,
                                bus.mem_write, bus.mem_addr_sel}), 0);
    reset_n = 1'b1;
    #1;
    check("rel_fetch_rd",  int'(bus.mem_read), 1);
    check("rel_fetch_sel", int'(bus.mem_addr_sel), 0);

    for (int i = 0; i < NV; i++) begin
      lat_t = vecs[i].lat + (HS ? vecs[i].fwait + vecs[i].mwait : 0);
      rd_t  = vecs[i].rd + ((vecs[i].rd != 0 && HS) ? vecs[i].mwait : 0);
      wr_t  = vecs[i].wr + ((vecs[i].wr != 0 && HS) ? vecs[i].mwait : 0);
      run_instr(vecs[i].instr, vecs[i].flag, vecs[i].fwait, vecs[i].mwait);
      check($sformatf("v%0d_timeout", i),   o_timeout, 0);
      check($sformatf("v%0d_op_decode", i), o_op_dec, int'(vecs[i].op));
      check($sformatf("v%0d_op_last", i),   o_op_end, int'(vecs[i].op));
      check($sformatf("v%0d_imm_exec", i),  o_imm_ex, vecs[i].imm);
      check($sformatf("v%0d_imm_cnt", i),   o_imm_cnt, vecs[i].imm);
      check($sformatf("v%0d_pc_branch", i), o_br, vecs[i].br);
      check($sformatf("v%0d_reg_write", i), o_rw, vecs[i].rw);
      check($sformatf("v%0d_rw_cycle", i),  o_rwc, (vecs[i].rw != 0) ? lat_t : 0);
      check($sformatf("v%0d_psr_write", i), o_pw, vecs[i].pw);
      check($sformatf("v%0d_mem_read", i),  o_rd, rd_t);
      check($sformatf("v%0d_mem_write", i), o_wr, wr_t);
      check($sformatf("v%0d_pc_inc", i),    o_pc, 1);
      check($sformatf("v%0d_ir_load", i),   o_irl, 1);
      check($sformatf("v%0d_latency", i),   o_lat, lat_t);
    end

    // Reset asserted while STOR is in MEM
    bus.instruction = 16'h4145;
    bus.flag_cond   = 1'b0;
    bus.mem_ready   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    #1;
    check("stor_mem_write", int'(bus.mem_write), 1);
    check("stor_mem_sel",   int'(bus.mem_addr_sel), 1);
    reset_n = 1'b0;
    #1;
    check("rst_async_write", int'(bus.mem_write), 0);
    check("rst_async_sel",   int'(bus.mem_addr_sel), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_rel_fetch", int'(bus.mem_read && !bus.mem_addr_sel), 1);
    wcnt = 0;
    lcnt = 0;
    for (int j = 0; j < 3; j++) begin
      wcnt += int'(bus.mem_write) + int'(bus.reg_write) + int'(bus.psr_write);
      lcnt += int'(bus.ir_load);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    check("rst_no_writes", wcnt, 0);
    check("rst_fetch_cnt", lcnt, HS ? 0 : 1);

    // Fetch with mem_ready low: waits only when the handshake is enabled
    @(negedge clk);
    pulse_reset();
    bus.instruction = 16'h51FD;
    bus.mem_ready   = 1'b0;
    #1;
    check("fetch_nready_irl", int'(bus.ir_load), HS ? 0 : 1);
    check("fetch_nready_pc",  int'(bus.pc_inc),  HS ? 0 : 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, limit 200000 reached");
    $fatal(1, "timeout");
  end

endmodule
